// File: rtl/ex_multicycle_divider.sv
// Iterative restoring radix-2 divider for DIV/DIVU in the EX stage: HI = remainder, LO = quotient.
// Optional DIVIDER_ZERO_FLAG_EN adds a div_by_zero status output.
module ex_multicycle_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
`ifdef DIVIDER_ZERO_FLAG_EN
    output logic             div_by_zero,
`endif
    output logic [WIDTH-1:0] result_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_q;   // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dsr_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign accept = (state == IDLE) && start && !flush;
    assign last   = (cnt == CW'(WIDTH - 1));

    assign dvd_mag = (is_signed && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
    assign dsr_mag = (is_signed && operand_2[WIDTH-1]) ? -operand_2 : operand_2;

    // One restoring step: a borrow out of the trial subtract means keep the shifted value.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr_q};
    assign q_bit   = ~diff[WIDTH];
    assign rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_nxt = {quo_q[WIDTH-2:0], q_bit};

    // Negation wraps modulo 2^WIDTH, so MIN / -1 naturally yields MIN.
    assign quo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
    assign rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;

    assign done  = (state == DONE);
    assign stall = accept || ((state == BUSY) && !flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
`ifdef DIVIDER_ZERO_FLAG_EN
            div_by_zero <= 1'b0;
`endif
        end else if (flush) begin
            // Kill leaves results and status untouched; only the sequencer is reset.
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo_q     <= dvd_mag;
                        dsr_q     <= dsr_mag;
                        rem_q     <= '0;
                        cnt       <= '0;
                        neg_quo_q <= is_signed && (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
                        neg_rem_q <= is_signed && operand_1[WIDTH-1];
                        if (operand_2 == '0) begin
                            state     <= DONE;
                            result_lo <= '1;
                            result_hi <= operand_1;
`ifdef DIVIDER_ZERO_FLAG_EN
                            div_by_zero <= 1'b1;
`endif
                        end else begin
                            state <= BUSY;
`ifdef DIVIDER_ZERO_FLAG_EN
                            div_by_zero <= 1'b0;
`endif
                        end
                    end
                end
                BUSY: begin
                    quo_q <= quo_nxt;
                    rem_q <= rem_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        result_lo <= quo_fix;
                        result_hi <= rem_fix;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_multicycle_divider.sv
// Directed bench for ex_multicycle_divider: latency, stall shape, signed/unsigned results, zero divisor, flush, reset.
module tb_ex_multicycle_divider;

    logic        clk = 1'b0;
    logic        rst, flush, start, is_signed;
    logic [31:0] operand_1, operand_2;
    logic        stall, done;
    logic [31:0] result_hi, result_lo;
`ifdef DIVIDER_ZERO_FLAG_EN
    logic        div_by_zero;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    ex_multicycle_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .is_signed(is_signed),
        .operand_1(operand_1), .operand_2(operand_2),
        .stall(stall), .done(done), .result_hi(result_hi),
`ifdef DIVIDER_ZERO_FLAG_EN
        .div_by_zero(div_by_zero),
`endif
        .result_lo(result_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division at the current cycle (T) and wait for done; lat counts edges until done.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input bit inject, input int exp_lat);
        int   lat;
        bit   got;
        logic stall_ok;
        operand_1 = a;
        operand_2 = b;
        is_signed = s;
        start     = 1'b1;
        #1;
        chk({tag, "_stall_T"}, {31'd0, stall}, 32'd1);
        lat = 0; got = 0; stall_ok = 1'b1;
        while (!got && lat < 100) begin
            tick();
            start     = 1'b0;
            operand_1 = 32'hDEAD_BEEF;
            operand_2 = 32'h0000_0003;
            lat++;
            if (done) got = 1;
            else begin
                stall_ok &= stall;
                if (inject && lat == 5) begin
                    start     = 1'b1;
                    operand_1 = 32'd7;
                    operand_2 = 32'd0;
                end
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
        #1;
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        int dsum;
        rst = 1'b1; flush = 1'b0; start = 1'b0; is_signed = 1'b0;
        operand_1 = '0; operand_2 = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_hi", result_hi, 32'd0);
        chk("rst_lo", result_lo, 32'd0);
`ifdef DIVIDER_ZERO_FLAG_EN
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
`endif
        tick();

        run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 0, 33);
        chk("divu_100_7_lo", result_lo, 32'd14);
        chk("divu_100_7_hi", result_hi, 32'd2);
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        run_div("div_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 0, 33);
        chk("div_m100_7_lo", result_lo, 32'hFFFF_FFF2);
        chk("div_m100_7_hi", result_hi, 32'hFFFF_FFFE);
        tick();

        run_div("div_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 0, 33);
        chk("div_100_m7_lo", result_lo, 32'hFFFF_FFF2);
        chk("div_100_m7_hi", result_hi, 32'd2);
        tick();

        run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 33);
        chk("div_min_m1_lo", result_lo, 32'h8000_0000);
        chk("div_min_m1_hi", result_hi, 32'd0);
        tick();

        run_div("divu_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 33);
        chk("divu_min_m1_lo", result_lo, 32'd0);
        chk("divu_min_m1_hi", result_hi, 32'h8000_0000);
        tick();

        run_div("dz", 32'h0000_1234, 32'd0, 1'b1, 0, 1);
        chk("dz_lo", result_lo, 32'hFFFF_FFFF);
        chk("dz_hi", result_hi, 32'h0000_1234);
`ifdef DIVIDER_ZERO_FLAG_EN
        chk("dz_flag", {31'd0, div_by_zero}, 32'd1);
`endif
        tick();

        // Second start while BUSY must not disturb timing or result.
        run_div("inject", 32'd1000, 32'd3, 1'b0, 1, 33);
        chk("inject_lo", result_lo, 32'd333);
        chk("inject_hi", result_hi, 32'd1);
`ifdef DIVIDER_ZERO_FLAG_EN
        chk("inject_flag", {31'd0, div_by_zero}, 32'd0);
`endif
        tick();

        // Flush at T+10 aborts 50/5; results keep 333/1; restart at T+12 with 9/2.
        operand_1 = 32'd50; operand_2 = 32'd5; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_idle_stall", {31'd0, stall}, 32'd0);
        chk("flush_no_done", {31'd0, done}, 32'd0);
        chk("flush_lo_kept", result_lo, 32'd333);
        chk("flush_hi_kept", result_hi, 32'd1);
        tick();
        run_div("after_flush", 32'd9, 32'd2, 1'b0, 0, 33);
        chk("after_flush_lo", result_lo, 32'd4);
        chk("after_flush_hi", result_hi, 32'd1);
        tick();

        // Flush and start together: nothing launches (zero divisor would show done at T+1).
        operand_1 = 32'd5; operand_2 = 32'd0; start = 1'b1; flush = 1'b1;
        #1;
        chk("fs_stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        #1;
        chk("fs_no_done", {31'd0, done}, 32'd0);
        chk("fs_lo_kept", result_lo, 32'd4);
        tick();

        // Flush during DONE: the pulse in that cycle still shows.
        operand_1 = 32'h55; operand_2 = 32'd0; start = 1'b1;
        tick();
        start = 1'b0; flush = 1'b1;
        #1;
        chk("flush_in_done", {31'd0, done}, 32'd1);
        tick();
        flush = 1'b0;
        chk("flush_in_done_after", {31'd0, done}, 32'd0);
        tick();

        // Reset at T+5 of a division clears everything and no done appears.
        operand_1 = 32'd50; operand_2 = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_hi", result_hi, 32'd0);
        chk("midrst_lo", result_lo, 32'd0);
        dsum = 0;
        repeat (40) begin
            tick();
            dsum += int'(done);
        end
        chk("midrst_no_done", dsum, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_multicycle_divider.md
Name: ex_multicycle_divider

Overview:
- EX-stage consumer of the ID-stage operand pair: takes operand_1 (dividend) and operand_2 (divisor) for DIV/DIVU.
- Iterative restoring radix-2 divider, one quotient bit per cycle.
- Holds the pipeline through a stall output and returns HI = remainder, LO = quotient.
- Sits beside the single-cycle ALU; the HI/LO write-back logic samples the results on done.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  pipeline flush (exception/branch kill); aborts an in-flight division
start  input  1  DIV/DIVU issued this cycle; operands valid while high
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
operand_1  input  WIDTH  dividend
operand_2  input  WIDTH  divisor
stall  output  1  request to hold the pipeline (combinational)
done  output  1  one-cycle pulse; result_hi/result_lo valid
result_hi  output  WIDTH  remainder
result_lo  output  WIDTH  quotient

Behaviour:
- Clock and reset: clk, rst; reset is synchronous and active-high.
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE, iteration counter=0, done=0, result_hi=0, result_lo=0, internal registers=0. Reset mid-BUSY aborts with no done.
- IDLE: start=1 and flush=0 latches the operands, sign flags and magnitudes.
  - Magnitude = |x| when is_signed, else raw.
  - If the divisor is nonzero: state goes to BUSY, counter=0.
- BUSY: each cycle shifts the partial remainder left, brings in the next dividend MSB, subtracts the divisor magnitude, and restores if the result is negative. Each cycle produces one quotient bit.
  - After WIDTH BUSY cycles the state goes to DONE.
- DONE: done=1 for exactly one cycle; the state returns to IDLE on the next edge.
- Latency: start sampled in cycle T; BUSY spans T+1..T+WIDTH; done=1 in cycle T+WIDTH+1.
- result_hi/result_lo update on the same edge that enters DONE and hold until the next completed division.
- stall = (state==IDLE & start & ~flush) | (state==BUSY). It is low in DONE, so the instruction advances with the result.
- Sign fixup (is_signed=1):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Arithmetic is modulo 2^WIDTH.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divisor zero: skip BUSY and go IDLE→DONE directly (done in cycle T+1). Results are lo={WIDTH{1}} and hi=operand_1 as latched, for both signedness modes.
- start while BUSY or DONE: ignored. Operands do not need to stay stable after cycle T.
- flush=1 in any state: next state IDLE, done=0 next cycle, results unchanged, stall=0 in that cycle.
  - flush and start in the same IDLE cycle: flush wins; nothing is launched.
  - flush in DONE: the done pulse in that cycle still asserts. The write-back logic must qualify it with its own flush.

Optional Feature:
- Macro DIVIDER_ZERO_FLAG_EN.
- When defined:
  - Adds output port div_by_zero (1 bit), reset 0.
  - div_by_zero is set together with done for a zero-divisor division, cleared on the next start accepted, and cleared by rst.
- When undefined: the port does not exist and zero-divisor results are as above with no indication.

Test Plan:
- DIVU: 100 / 7, start 1 cycle -> stall high cycles T..T+32, done pulse at T+33, lo=14, hi=2.
- DIV: 0xFFFFFF9C (-100) / 7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2). Repeat 100 / 0xFFFFFFF9 -> lo=0xFFFFFFF2, hi=2.
- DIV: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU same operands -> lo=0, hi=0x80000000.
- Divisor 0, operand_1=0x1234 -> done at T+1, lo=0xFFFFFFFF, hi=0x1234; with DIVIDER_ZERO_FLAG_EN, div_by_zero=1.
- Start 50/5, flush at T+10 -> IDLE at T+11, no done pulse, results keep prior values. A new start at T+12 of 9/2 -> done at T+45, lo=4, hi=1.
- rst at T+5 of a division -> all outputs 0 next cycle. A second start pulse during BUSY has no effect on timing or result.
